// File: rtl/cache_pkg.sv
// Shared types and constants for the cache controller.
// Contents: FSM state enum, block geometry, and default bus widths.
package cache_pkg;

    localparam int unsigned BLOCK_WORDS = 4;
    localparam int unsigned OFFS_W      = $clog2(BLOCK_WORDS);
    localparam int unsigned DEF_ADDR_W  = 15;
    localparam int unsigned DEF_DATA_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CHECK,
        ST_MEM_WAIT,
        ST_FILL,
        ST_RESPOND
    } state_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// Bus bundle between the cache controller and its CPU, cache array and memory.
// master: controller side (drives cpu_ready/cpu_data/cache_addr/cache_write/mem_req/mem_addr).
// slave : environment side (drives cpu_req/cpu_addr/cache_hit/cache_miss/cache_rdata/mem_ready).
interface cache_ctrl_if
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_data;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_hit;
    logic              cache_miss;
    logic [DATA_W-1:0] cache_rdata;
    logic              cache_write;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;

    modport master (
        input  cpu_req, cpu_addr, cache_hit, cache_miss, cache_rdata, mem_ready,
        output cpu_ready, cpu_data, cache_addr, cache_write, mem_req, mem_addr
    );

    modport slave (
        output cpu_req, cpu_addr, cache_hit, cache_miss, cache_rdata, mem_ready,
        input  cpu_ready, cpu_data, cache_addr, cache_write, mem_req, mem_addr
    );
endinterface

// File: rtl/sat_counter.sv
// W-bit saturating incrementer with synchronous clear.
// Ports: clk, clr (sync clear), inc (count enable), count (current value).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    // Holds at all-ones once reached.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/cache_ctrl.sv
// Read-only cache controller: lookup, miss handling with block fill, re-check, respond.
// Ports: clk, rst (sync, active-high), bus (cache_ctrl_if.master), hit_count, miss_count.
// Macro CACHE_STATS_EN: when defined, hit/miss counters are saturating flops;
// otherwise both count outputs are tied to zero.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    cache_ctrl_if.master     bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic              cpu_ready_q, cpu_ready_nx;
    logic [DATA_W-1:0] cpu_data_q, cpu_data_nx;
    logic              cache_write_q, cache_write_nx;
    logic              mem_req_q, mem_req_nx;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            cpu_ready_q   <= 1'b0;
            cpu_data_q    <= '0;
            cache_write_q <= 1'b0;
            mem_req_q     <= 1'b0;
        end else begin
            state         <= state_nx;
            addr_q        <= addr_nx;
            cpu_ready_q   <= cpu_ready_nx;
            cpu_data_q    <= cpu_data_nx;
            cache_write_q <= cache_write_nx;
            mem_req_q     <= mem_req_nx;
        end
    end

    // Next-state logic; a miss flag wins over a simultaneous hit flag.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (bus.cpu_req) state_nx = ST_LOOKUP;
            ST_LOOKUP:   state_nx = ST_CHECK;
            ST_CHECK: begin
                if (bus.cache_miss)     state_nx = ST_MEM_WAIT;
                else if (bus.cache_hit) state_nx = ST_RESPOND;
            end
            ST_MEM_WAIT: if (bus.mem_ready) state_nx = ST_FILL;
            ST_FILL:     state_nx = ST_LOOKUP;
            ST_RESPOND:  state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Output next values; mem_req/cache_write are keyed off the next state so
    // they line up with MEM_WAIT/FILL, cpu_ready/cpu_data capture the RESPOND cycle.
    always_comb begin
        addr_nx        = addr_q;
        cpu_data_nx    = cpu_data_q;
        cpu_ready_nx   = 1'b0;
        mem_req_nx     = 1'b0;
        cache_write_nx = 1'b0;
        if ((state == ST_IDLE) && bus.cpu_req) addr_nx = bus.cpu_addr;
        if (state == ST_RESPOND) begin
            cpu_ready_nx = 1'b1;
            cpu_data_nx  = bus.cache_rdata;
        end
        mem_req_nx     = (state_nx == ST_MEM_WAIT);
        cache_write_nx = (state_nx == ST_FILL);
    end

    assign bus.cache_addr  = (state == ST_IDLE) ? bus.cpu_addr : addr_q;
    assign bus.mem_addr    = {addr_q[ADDR_W-1:OFFS_W], OFFS_W'(0)};
    assign bus.cpu_ready   = cpu_ready_q;
    assign bus.cpu_data    = cpu_data_q;
    assign bus.cache_write = cache_write_q;
    assign bus.mem_req     = mem_req_q;

`ifdef CACHE_STATS_EN
    logic hit_inc, miss_inc;
    assign hit_inc  = (state == ST_CHECK) && (state_nx == ST_RESPOND);
    assign miss_inc = (state == ST_CHECK) && (state_nx == ST_MEM_WAIT);

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: per-transaction timeline model with
// randomized cache/memory behaviour and a saturating statistics model.
module tb_cache_ctrl;
    import cache_pkg::*;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [CW-1:0] hit_count, miss_count;

    cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int total = 0;
    int bad   = 0;
    int n_hit = 0;
    int n_miss = 0;
    logic [DW-1:0] last_data = '0;

    function automatic logic [CW-1:0] exp_cnt(input int n);
        int mx = (1 << CW) - 1;
        if (!STATS) return '0;
        return (n > mx) ? CW'(mx) : CW'(n);
    endfunction

    // One read transaction; c counts clock edges after the acceptance edge.
    task automatic run_txn(input logic [AW-1:0] a, input int d1, input bit miss,
                           input bit both, input int nmw, input int d2,
                           input bit drop, input logic [DW-1:0] rdata);
        int c_dec1, mw_lo, mw_hi, fill, chk2_lo, c_dec2, resp, tot;
        logic exp_req, exp_wr, exp_rdy;
        c_dec1  = 1 + d1;
        mw_lo   = 2 + d1;
        mw_hi   = 1 + d1 + nmw;
        fill    = 2 + d1 + nmw;
        chk2_lo = 4 + d1 + nmw;
        c_dec2  = chk2_lo + d2;
        resp    = miss ? c_dec2 + 1 : c_dec1 + 1;
        tot     = resp + 1;
        if (miss) begin n_miss++; n_hit++; end
        else n_hit++;

        bus.cpu_req     = 1'b1;
        bus.cpu_addr    = a;
        bus.cache_hit   = 1'($urandom);
        bus.cache_miss  = 1'($urandom);
        bus.mem_ready   = 1'($urandom);
        bus.cache_rdata = $urandom;
        #1;
        total++;
        if (bus.cache_addr !== a) begin
            bad++;
            $display("FAIL idle_cache_addr got=%h want=%h", bus.cache_addr, a);
        end
        @(posedge clk); #1;
        for (int c = 0; c <= tot; c++) begin
            exp_req = miss && (c >= mw_lo) && (c <= mw_hi);
            exp_wr  = miss && (c == fill);
            exp_rdy = (c == tot);
            total += 3;
            if (bus.mem_req !== exp_req) begin
                bad++;
                $display("FAIL mem_req c=%0d got=%b want=%b", c, bus.mem_req, exp_req);
            end
            if (bus.cache_write !== exp_wr) begin
                bad++;
                $display("FAIL cache_write c=%0d got=%b want=%b", c, bus.cache_write, exp_wr);
            end
            if (bus.cpu_ready !== exp_rdy) begin
                bad++;
                $display("FAIL cpu_ready c=%0d got=%b want=%b", c, bus.cpu_ready, exp_rdy);
            end
            if (exp_req) begin
                total++;
                if (bus.mem_addr !== {a[AW-1:2], 2'b00}) begin
                    bad++;
                    $display("FAIL mem_addr c=%0d got=%h want=%h", c, bus.mem_addr, {a[AW-1:2], 2'b00});
                end
            end
            total++;
            if (exp_rdy) begin
                if (bus.cpu_data !== rdata) begin
                    bad++;
                    $display("FAIL cpu_data got=%h want=%h", bus.cpu_data, rdata);
                end
                last_data = rdata;
                total += 2;
                if (hit_count !== exp_cnt(n_hit)) begin
                    bad++;
                    $display("FAIL hit_count got=%0d want=%0d", hit_count, exp_cnt(n_hit));
                end
                if (miss_count !== exp_cnt(n_miss)) begin
                    bad++;
                    $display("FAIL miss_count got=%0d want=%0d", miss_count, exp_cnt(n_miss));
                end
            end else if (bus.cpu_data !== last_data) begin
                bad++;
                $display("FAIL cpu_data_hold c=%0d got=%h want=%h", c, bus.cpu_data, last_data);
            end

            bus.cpu_req     = (c == tot) ? 1'b0 : !drop;
            bus.cpu_addr    = AW'($urandom);
            bus.cache_hit   = 1'($urandom);
            bus.cache_miss  = 1'($urandom);
            bus.mem_ready   = 1'($urandom);
            bus.cache_rdata = (c == resp) ? rdata : $urandom;
            if ((c >= 1 && c < c_dec1) || (miss && c >= chk2_lo && c < c_dec2)) begin
                bus.cache_hit  = 1'b0;
                bus.cache_miss = 1'b0;
            end else if (c == c_dec1) begin
                bus.cache_hit  = miss ? both : 1'b1;
                bus.cache_miss = miss;
            end else if (miss && c == c_dec2) begin
                bus.cache_hit  = 1'b1;
                bus.cache_miss = 1'b0;
            end
            if (miss && c >= mw_lo && c <= mw_hi) bus.mem_ready = (c == mw_hi);
            #1;
            total++;
            if (c < tot) begin
                if (bus.cache_addr !== a) begin
                    bad++;
                    $display("FAIL cache_addr c=%0d got=%h want=%h", c, bus.cache_addr, a);
                end
                @(posedge clk); #1;
            end else if (bus.cache_addr !== bus.cpu_addr) begin
                bad++;
                $display("FAIL idle_cache_addr got=%h want=%h", bus.cache_addr, bus.cpu_addr);
            end
        end
    endtask

    // Idle cycles with junk on cache/memory inputs: nothing may fire.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cpu_req     = 1'b0;
            bus.cpu_addr    = AW'($urandom);
            bus.cache_hit   = 1'($urandom);
            bus.cache_miss  = 1'($urandom);
            bus.mem_ready   = 1'($urandom);
            bus.cache_rdata = $urandom;
            @(posedge clk); #1;
            total++;
            if (bus.cpu_ready !== 1'b0 || bus.mem_req !== 1'b0 || bus.cache_write !== 1'b0
                || bus.cpu_data !== last_data) begin
                bad++;
                $display("FAIL idle_outputs rdy=%b req=%b wr=%b data=%h want 0/0/0/%h",
                         bus.cpu_ready, bus.mem_req, bus.cache_write, bus.cpu_data, last_data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cpu_req = 1'b1;
        bus.cpu_addr = 15'h7FFF;
        bus.cache_hit = 1'b1;
        bus.cache_miss = 1'b1;
        bus.mem_ready = 1'b1;
        bus.cache_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.cpu_ready !== 1'b0 || bus.cpu_data !== '0 || bus.cache_write !== 1'b0
            || bus.mem_req !== 1'b0 || bus.mem_addr !== '0 || hit_count !== '0 || miss_count !== '0) begin
            bad++;
            $display("FAIL reset_state rdy=%b data=%h wr=%b req=%b maddr=%h hc=%0d mc=%0d want all 0",
                     bus.cpu_ready, bus.cpu_data, bus.cache_write, bus.mem_req, bus.mem_addr,
                     hit_count, miss_count);
        end
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        n_hit = 0; n_miss = 0; last_data = '0;
        idle(2);
    endtask

    task automatic test_hit();
        run_txn(15'h0123, 0, 1'b0, 1'b0, 0, 0, 1'b0, 32'hDEADBEEF);
        idle(1);
    endtask

    task automatic test_miss();
        run_txn(15'h1ABF, 0, 1'b1, 1'b0, 3, 0, 1'b0, 32'h1234_5678);
        idle(1);
    endtask

    task automatic test_both_flags();
        run_txn(AW'($urandom), 1, 1'b1, 1'b1, 1, 1, 1'b0, $urandom);
        total++;
        if (miss_count !== exp_cnt(n_miss)) begin
            bad++;
            $display("FAIL both_flags_miss_count got=%0d want=%0d", miss_count, exp_cnt(n_miss));
        end
        idle(1);
    endtask

    // Reset during the second MEM_WAIT cycle, or during FILL.
    task automatic test_reset_mid(input bit at_fill);
        bus.cpu_req = 1'b1;
        bus.cpu_addr = 15'h2F05;
        bus.cache_hit = 1'b0;
        bus.cache_miss = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        bus.cache_miss = 1'b1;
        @(posedge clk); #1;
        bus.cache_miss = 1'b0;
        bus.mem_ready = at_fill;
        total++;
        if (bus.mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_mem_req got=%b want=1", bus.mem_req);
        end
        @(posedge clk); #1;
        total++;
        if ((at_fill ? bus.cache_write : bus.mem_req) !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_strobe fill=%0d got wr=%b req=%b", at_fill, bus.cache_write, bus.mem_req);
        end
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        total++;
        if (bus.mem_req !== 1'b0 || bus.cache_write !== 1'b0 || bus.cpu_ready !== 1'b0
            || hit_count !== '0 || miss_count !== '0) begin
            bad++;
            $display("FAIL rst_mid req=%b wr=%b rdy=%b hc=%0d mc=%0d want all 0",
                     bus.mem_req, bus.cache_write, bus.cpu_ready, hit_count, miss_count);
        end
        n_hit = 0; n_miss = 0; last_data = '0;
        idle(6);
        run_txn(AW'($urandom), 0, 1'b0, 1'b0, 0, 0, 1'b0, $urandom);
        idle(1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) run_txn(AW'($urandom), i % 2, 1'b0, 1'b0, 0, 0, 1'b0, $urandom);
        total++;
        if (hit_count !== exp_cnt(n_hit)) begin
            bad++;
            $display("FAIL saturation_hit got=%0d want=%0d", hit_count, exp_cnt(n_hit));
        end
        idle(1);
    endtask

    task automatic test_drop();
        run_txn(AW'($urandom), 0, 1'b1, 1'b0, 2, 0, 1'b1, $urandom);
        run_txn(AW'($urandom), 0, 1'b1, 1'b0, 1, 1, 1'b0, $urandom);
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 25; i++) begin
            run_txn(AW'($urandom), $urandom_range(2), 1'($urandom), 1'($urandom),
                    $urandom_range(5, 1), $urandom_range(2), 1'($urandom), $urandom);
            if ($urandom_range(2) != 0) idle($urandom_range(2, 1));
        end
        idle(2);
    endtask

    initial begin
        bus.cpu_req = 1'b0;
        bus.cpu_addr = '0;
        bus.cache_hit = 1'b0;
        bus.cache_miss = 1'b0;
        bus.cache_rdata = '0;
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        test_reset();
        test_hit();
        test_miss();
        test_both_flags();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_saturation();
        test_drop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
